key_debounce: RTL
=================

Name: key_debounce

Overview:
- Conditions one raw mechanical push-button into clean, single-clock-cycle event pulses.
- Its `key_press` output feeds the `inp` input of the downstream timer/counter stage.
- Provides:
  - a synchronised, debounced level;
  - press and release pulses;
  - a long-press / auto-repeat pulse train, so the timer can be stepped quickly while the key is held.

Parameters:
- STABLE_CYCLES, 1_000_000: consecutive cycles the synchronised input must hold a new value before the debounced level changes (10 ms at 100 MHz). Legal range ≥ 1.
- LONG_CYCLES, 50_000_000: cycles after the press pulse until the first key_hold pulse. 0 disables key_hold entirely.
- REPEAT_CYCLES, 10_000_000: period of subsequent key_hold pulses while the key stays pressed. 0 gives a single hold pulse with no repeat.
- ACTIVE_HIGH, 1: 1 = pressed key drives key_in high; 0 = pressed key drives key_in low (inverted internally after synchronisation).

Ports:
- clk, input, 1: system clock; all flops on posedge.
- rst, input, 1: asynchronous, active-high reset.
- key_in, input, 1: raw asynchronous button pin, may bounce.
- key_level, output, 1: debounced level; 1 = pressed.
- key_press, output, 1: one-cycle pulse on debounced 0→1.
- key_release, output, 1: one-cycle pulse on debounced 1→0.
- key_hold, output, 1: one-cycle pulse(s) during a long press.

Behaviour:
- **Reset**
  - Asynchronous reset forces all outputs to 0 and the FSM to IDLE.
  - It clears the debounce and hold counters.
  - It loads the synchroniser flops with the "released" value (0 after polarity correction).
  - Reset asserted mid-press discards that press: no release pulse is generated.
  - After reset deasserts, a key still held down must pass a full debounce before key_press fires.
- **Synchroniser**
  - Two flops on key_in, followed by polarity inversion when ACTIVE_HIGH = 0. The result is key_s.
- **Debounce counter**
  - Width is $clog2(STABLE_CYCLES+1).
  - Increments each cycle key_s != key_level; otherwise clears to 0.
  - When it reaches STABLE_CYCLES-1 while key_s still differs, on that edge:
    - key_level toggles;
    - the counter clears;
    - the FSM transitions.
  - Any single-cycle return of key_s to key_level restarts the count from 0. Glitches shorter than STABLE_CYCLES never reach the outputs.
- **Latency**
  - A clean step on key_in sampled at edge 0 makes key_level, and the key_press pulse, visible after edge STABLE_CYCLES+2.
  - Release latency is identical.
- **FSM states**
  - IDLE (key_level 0):
    - debounced rise → PRESSED;
    - key_press = 1 for exactly one cycle;
    - hold counter cleared.
  - PRESSED (key_level 1):
    - hold counter increments each cycle;
    - when it reaches LONG_CYCLES-1 and LONG_CYCLES != 0 → REPEAT, with key_hold = 1 for one cycle and the counter cleared;
    - debounced fall → IDLE with key_release = 1.
  - REPEAT (key_level 1):
    - hold counter increments;
    - when it reaches REPEAT_CYCLES-1 and REPEAT_CYCLES != 0: key_hold pulses and the counter clears;
    - when REPEAT_CYCLES = 0: the counter saturates and no further pulses are produced;
    - debounced fall → IDLE with key_release = 1.
- **Hold counter**
  - Width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
  - It never wraps; it saturates at its maximum.
- **Mutual exclusion**
  - key_press, key_release and key_hold are mutually exclusive in any cycle.
  - If a debounced fall coincides with a hold-terminal count, key_release wins and key_hold is suppressed.
- **Output timing**
  - All outputs are registered; there are no combinational paths from key_in.

Decomposition:
- Package key_debounce_pkg holds:
  - the FSM state encoding localparams: IDLE = 2'd0, PRESSED = 2'd1, REPEAT = 2'd2; 2'd3 is illegal and recovers to IDLE;
  - the clog2 width helper function.
- Sub-module sync_2ff: the two-flop synchroniser, with reset value and width parameterised.
  - Reused later for other asynchronous pins such as switches.

Test Plan (bench parameters: STABLE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_HIGH=1):
- Clean press: key_in 0→1 at edge 0, held 20 cycles.
  - Required: key_level rises after edge 6.
  - Required: key_press high for exactly cycle 6 only; no key_release.
- Bounce: key_in toggles 1,0,1,0 for one cycle each, then holds 1.
  - Required: the count restarts on every toggle.
  - Required: a single key_press 6 edges after the final rise; key_level never glitches.
- Long press with repeat: hold key_in = 1 for 40 cycles.
  - Required: key_hold pulses 10 cycles after key_press, then every 5 cycles.
  - Required: key_release 6 edges after key_in falls.
- Short glitch: key_in = 1 for 3 cycles only.
  - Required: key_level, key_press, key_hold and key_release all stay 0.
- Reset mid-press: assert rst while key_level = 1, with key_in still 1.
  - Required: all outputs 0 immediately (asynchronously).
  - Required: after deassertion, key_press again 6 edges later; no release pulse.
- Polarity: ACTIVE_HIGH=0 and a key_in 1→0 step.
  - Required: key_press after 6 edges; identical waveform to the first scenario.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button conditioning block.
// The FSM encoding is fixed so that 2'd3 is the only illegal code.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  // Counter width for values 0..value-1, never narrower than one bit.
  function automatic int clog2_w(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; width and reset value
// are parameters so the same block serves buttons and switches.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce, then derive registered
// press / release / long-press auto-repeat pulses for the timer stage.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);

  localparam int DW = clog2_w(STABLE_CYCLES + 1);
  localparam int HW = clog2_w(max_i(LONG_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [DW-1:0] DEB_TERM  = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_TERM = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;
  localparam logic          RAW_IDLE  = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  logic          w_key_raw;
  logic          w_key_s;

  logic [DW-1:0] r_deb_cnt;
  logic          r_deb_level;
  logic          r_rise;
  logic          r_fall;

  state_t        r_state;
  state_t        w_state_next;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_next;
  logic [HW-1:0] w_hold_inc;

  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_hold;
  logic          w_press_next;
  logic          w_release_next;
  logic          w_hold_next;

  // Synchroniser resets to the raw "released" level for either polarity.
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(RAW_IDLE)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(key_in),
    .o_q(w_key_raw)
  );

  assign w_key_s = (ACTIVE_HIGH != 0) ? w_key_raw : ~w_key_raw;

  // Any cycle where key_s matches the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_key_s != r_deb_level) begin
        if (r_deb_cnt == DEB_TERM) begin
          r_deb_cnt   <= '0;
          r_deb_level <= w_key_s;
          r_rise      <= w_key_s;
          r_fall      <= ~w_key_s;
        end else begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_level    <= (w_state_next != IDLE);
      r_press    <= w_press_next;
      r_release  <= w_release_next;
      r_hold     <= w_hold_next;
    end
  end

  // A debounced fall is checked first so release always beats a hold pulse.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_press_next    = 1'b0;
    w_release_next  = 1'b0;
    w_hold_next     = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_cnt_next = '0;
        if (r_rise) begin
          w_state_next = PRESSED;
          w_press_next = 1'b1;
        end
      end
      PRESSED: begin
        if (r_fall) begin
          w_state_next    = IDLE;
          w_release_next  = 1'b1;
          w_hold_cnt_next = '0;
        end else if ((LONG_CYCLES != 0) && (r_hold_cnt == LONG_TERM)) begin
          w_state_next    = REPEAT;
          w_hold_next     = 1'b1;
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = w_hold_inc;
        end
      end
      REPEAT: begin
        if (r_fall) begin
          w_state_next    = IDLE;
          w_release_next  = 1'b1;
          w_hold_cnt_next = '0;
        end else if ((REPEAT_CYCLES != 0) && (r_hold_cnt == REP_TERM)) begin
          w_hold_next     = 1'b1;
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = w_hold_inc;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_hold    = r_hold;

endmodule
